window_ctrl: RTL

//   Sequences a SIZE x SIZE Buffer as a sliding window over an IMG_H x IMG_W image held in
//   an external byte memory. Issues one read at a time and writes returned pixels into the

---
 rtl/window_ctrl_pkg.sv | 16 +
 rtl/window_ctrl_if.sv | 39 +++
 rtl/win_addr_gen.sv | 18 +
 rtl/window_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/window_ctrl_pkg.sv
// rtl/window_ctrl_pkg.sv - shared state encoding and index width for window_ctrl
package window_ctrl_pkg;

   // Buffer index ports and window coordinates are this wide.
   localparam int IDX_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD_FULL = 3'd1,
      ST_WIN       = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_LOAD_COL  = 3'd4,
      ST_FINISH    = 3'd5
   } state_t;

endpackage

// File: rtl/window_ctrl_if.sv
// rtl/window_ctrl_if.sv - memory read, Buffer control and window handshake bundle
interface window_ctrl_if #(
   parameter int AW = 16
) ();
   import window_ctrl_pkg::*;

   logic             start;
   logic             rd_req;
   logic [AW-1:0]    rd_addr;
   logic             rd_valid;
   logic [7:0]       rd_data;
   logic             buf_wr_en;
   logic             buf_shift_up;
   logic             buf_shift_left;
   logic [IDX_W-1:0] buf_idx_i;
   logic [IDX_W-1:0] buf_idx_j;
   logic [7:0]       buf_data_in;
   logic             win_valid;
   logic             win_ack;
   logic [IDX_W-1:0] win_row;
   logic [IDX_W-1:0] win_col;
   logic             busy;
   logic             done;

   modport master (
      input  start, rd_valid, rd_data, win_ack,
      output rd_req, rd_addr, buf_wr_en, buf_shift_up, buf_shift_left,
             buf_idx_i, buf_idx_j, buf_data_in, win_valid, win_row, win_col,
             busy, done
   );

   modport slave (
      output start, rd_valid, rd_data, win_ack,
      input  rd_req, rd_addr, buf_wr_en, buf_shift_up, buf_shift_left,
             buf_idx_i, buf_idx_j, buf_data_in, win_valid, win_row, win_col,
             busy, done
   );

endinterface

// File: rtl/win_addr_gen.sv
// rtl/win_addr_gen.sv - pixel address from window corner plus in-window offset
module win_addr_gen
   import window_ctrl_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int AW    = 16
) (
   input  logic [IDX_W-1:0] win_row,
   input  logic [IDX_W-1:0] win_col,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [IDX_W-1:0] idx_j,
   output logic [AW-1:0]    rd_addr
);

   // Row-major linear address; legal parameters keep the product below 2**AW.
   assign rd_addr = AW'((win_row + idx_i) * IDX_W'(IMG_W) + win_col + idx_j);

endmodule

// File: rtl/window_ctrl.sv
// rtl/window_ctrl.sv - sliding-window sequencer: fills the Buffer and hands windows downstream
module window_ctrl
   import window_ctrl_pkg::*;
#(
   parameter int SIZE  = 4,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int AW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   window_ctrl_if.master bus
);

   localparam logic [IDX_W-1:0] LAST    = IDX_W'(SIZE - 1);
   localparam logic [IDX_W-1:0] COL_MAX = IDX_W'(IMG_W - SIZE);
   localparam logic [IDX_W-1:0] ROW_MAX = IDX_W'(IMG_H - SIZE);
   localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

   state_t           state, state_n;
   logic [IDX_W-1:0] win_row, win_row_n;
   logic [IDX_W-1:0] win_col, win_col_n;
   logic [IDX_W-1:0] idx_i, idx_i_n;
   logic [IDX_W-1:0] idx_j, idx_j_n;
   logic             rd_req, wr_en, shift_left, win_valid, busy, done;
   logic [AW-1:0]    rd_addr;

   win_addr_gen #(
      .IMG_W (IMG_W),
      .AW    (AW)
   ) u_addr_gen (
      .win_row (win_row),
      .win_col (win_col),
      .idx_i   (idx_i),
      .idx_j   (idx_j),
      .rd_addr (rd_addr)
   );

   // State and window/element counters; reset drops straight back to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         win_row <= '0;
         win_col <= '0;
         idx_i   <= '0;
         idx_j   <= '0;
      end else begin
         state   <= state_n;
         win_row <= win_row_n;
         win_col <= win_col_n;
         idx_i   <= idx_i_n;
         idx_j   <= idx_j_n;
      end
   end

   // Next state, counter updates and per-state outputs.
   always_comb begin
      state_n    = state;
      win_row_n  = win_row;
      win_col_n  = win_col;
      idx_i_n    = idx_i;
      idx_j_n    = idx_j;
      rd_req     = 1'b0;
      wr_en      = 1'b0;
      shift_left = 1'b0;
      win_valid  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (bus.start) begin
               win_row_n = '0;
               win_col_n = '0;
               idx_i_n   = '0;
               idx_j_n   = '0;
               state_n   = ST_LOAD_FULL;
            end
         end
         ST_LOAD_FULL: begin
            rd_req = 1'b1;
            wr_en  = bus.rd_valid;
            if (bus.rd_valid) begin
               if (idx_j == LAST) begin
                  idx_j_n = '0;
                  if (idx_i == LAST) begin
                     idx_i_n = '0;
                     state_n = ST_WIN;
                  end else begin
                     idx_i_n = idx_i + ONE;
                  end
               end else begin
                  idx_j_n = idx_j + ONE;
               end
            end
         end
         ST_WIN: begin
            win_valid = 1'b1;
            if (bus.win_ack) begin
               if (win_col < COL_MAX) begin
                  state_n = ST_SHIFT;
               end else if (win_row < ROW_MAX) begin
                  win_row_n = win_row + ONE;
                  win_col_n = '0;
                  idx_i_n   = '0;
                  idx_j_n   = '0;
                  state_n   = ST_LOAD_FULL;
               end else begin
                  state_n = ST_FINISH;
               end
            end
         end
         ST_SHIFT: begin
            // Only the new rightmost column needs fetching after the shift.
            shift_left = 1'b1;
            win_col_n  = win_col + ONE;
            idx_i_n    = '0;
            idx_j_n    = LAST;
            state_n    = ST_LOAD_COL;
         end
         ST_LOAD_COL: begin
            rd_req = 1'b1;
            wr_en  = bus.rd_valid;
            if (bus.rd_valid) begin
               if (idx_i == LAST) begin
                  idx_i_n = '0;
                  state_n = ST_WIN;
               end else begin
                  idx_i_n = idx_i + ONE;
               end
            end
         end
         ST_FINISH: begin
            done    = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.rd_req         = rd_req;
   assign bus.rd_addr        = rd_addr;
   assign bus.buf_wr_en      = wr_en;
   assign bus.buf_shift_up   = 1'b0;
   assign bus.buf_shift_left = shift_left;
   assign bus.buf_idx_i      = idx_i;
   assign bus.buf_idx_j      = idx_j;
   assign bus.buf_data_in    = bus.rd_data;
   assign bus.win_valid      = win_valid;
   assign bus.win_row        = win_row;
   assign bus.win_col        = win_col;
   assign bus.busy           = busy;
   assign bus.done           = done;

endmodule
